// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Buffers 3-bit signed samples from a valid/ready source in a small FIFO.
//   It divides the 12 MHz clock down to a 600 kHz strobe, and on each strobe
//   it hands exactly one sample to the FIR filter.
//
// Parameters
//   DIV    clock cycles per strobe (2..1023)
//   DEPTH  FIFO depth, power of two, >= 2
//
// Ports
//   iClk_12MHz        system clock
//   iRst              asynchronous active-high reset
//   iEnable           strobe generation enable
//   iClrFlag          synchronous clear of the underflow flag/counter
//   iSampleValid      source sample valid
//   iSample           source sample (signed)
//   oSampleReady      FIFO has room (combinational from registered level)
//   oEnSample_600kHz  one-cycle strobe to the FIR
//   oFirIn            sample to the FIR, held between strobes
//   oFifoLevel        FIFO occupancy 0..DEPTH
//   oUnderflow        sticky: a strobe found the FIFO empty
//   oUnderflowCnt     16-bit saturating underflow count
//                     (only when FEEDER_UNDERFLOW_CNT_EN is defined)
module fir_sample_feeder #(
    parameter int DIV   = 20,
    parameter int DEPTH = 4
) (
    input  logic                       iClk_12MHz,
    input  logic                       iRst,
    input  logic                       iEnable,
    input  logic                       iClrFlag,
    input  logic                       iSampleValid,
    input  logic signed [2:0]          iSample,
    output logic                       oSampleReady,
    output logic                       oEnSample_600kHz,
    output logic signed [2:0]          oFirIn,
    output logic [$clog2(DEPTH):0]     oFifoLevel,
`ifdef FEEDER_UNDERFLOW_CNT_EN
    output logic [15:0]                oUnderflowCnt,
`endif
    output logic                       oUnderflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    logic signed [2:0]   mem_q [DEPTH];
    logic                en_q;
    logic signed [2:0]   fir_q, fir_d;
    logic                uf_q, uf_d;

    logic strobe_edge, empty, push, pop, underflow;

    assign empty        = (level_q == '0);
    assign oSampleReady = (level_q != LVL_FULL);
    assign push         = iSampleValid && oSampleReady;
    assign strobe_edge  = iEnable && (cnt_q == CNT_LAST);
    assign pop          = strobe_edge && !empty;
    // No bypass: a push into an empty FIFO on a strobe edge still underflows.
    assign underflow    = strobe_edge && empty;

    always_comb begin
        cnt_d   = '0;
        if (iEnable)
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        level_d = level_q + LW'(push) - LW'(pop);
        fir_d   = fir_q;
        if (pop)
            fir_d = mem_q[rd_ptr_q];
        else if (underflow)
            fir_d = '0;
        // Underflow on the same edge as a clear wins.
        uf_d = uf_q;
        if (iClrFlag)
            uf_d = 1'b0;
        if (underflow)
            uf_d = 1'b1;
    end

    always_ff @(posedge iClk_12MHz or posedge iRst) begin
        if (iRst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            en_q     <= 1'b0;
            fir_q    <= '0;
            uf_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            en_q    <= strobe_edge;
            fir_q   <= fir_d;
            uf_q    <= uf_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers and level define validity.
    always_ff @(posedge iClk_12MHz) begin
        if (push && !iRst)
            mem_q[wr_ptr_q] <= iSample;
    end

`ifdef FEEDER_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (iClrFlag)
            ucnt_d = '0;
        if (underflow) begin
            if (iClrFlag)
                ucnt_d = 16'd1;
            else if (ucnt_q != 16'hFFFF)
                ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge iClk_12MHz or posedge iRst) begin
        if (iRst)
            ucnt_q <= '0;
        else
            ucnt_q <= ucnt_d;
    end

    assign oUnderflowCnt = ucnt_q;
`endif

    assign oEnSample_600kHz = en_q;
    assign oFirIn           = fir_q;
    assign oFifoLevel       = level_q;
    assign oUnderflow       = uf_q;
endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;
    logic              clk = 1'b0;
    logic              rst;
    logic              en, clr, vld;
    logic signed [2:0] smp;
    logic              rdy, stb, uf;
    logic signed [2:0] fir;
    logic [2:0]        lvl;
`ifdef FEEDER_UNDERFLOW_CNT_EN
    logic [15:0]       ucnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_sample_feeder #(.DIV(20), .DEPTH(4)) dut (
        .iClk_12MHz       (clk),
        .iRst             (rst),
        .iEnable          (en),
        .iClrFlag         (clr),
        .iSampleValid     (vld),
        .iSample          (smp),
        .oSampleReady     (rdy),
        .oEnSample_600kHz (stb),
        .oFirIn           (fir),
        .oFifoLevel       (lvl),
`ifdef FEEDER_UNDERFLOW_CNT_EN
        .oUnderflowCnt    (ucnt),
`endif
        .oUnderflow       (uf)
    );

    typedef struct {
        logic              v;
        logic signed [2:0] s;
        logic              exp_rdy;
        logic [2:0]        exp_lvl;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps n cycles expecting no strobe in any of them.
    task automatic quiet(input int n, input string name);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (stb) seen++;
        end
        chk(name, seen, 0);
    endtask

    // Steps until a strobe is seen; returns cycles taken (bounded).
    task automatic wait_strobe(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            step();
            n++;
            if (stb) break;
        end
        if (!stb) n = -1;
    endtask

    int n;

    initial begin
        vecs[0] = '{1'b1, -3'sd4, 1'b1, 3'd1};
        vecs[1] = '{1'b1, -3'sd1, 1'b1, 3'd2};
        vecs[2] = '{1'b1,  3'sd0, 1'b1, 3'd3};
        vecs[3] = '{1'b1,  3'sd3, 1'b0, 3'd4};
        vecs[4] = '{1'b1,  3'sd1, 1'b0, 3'd4};  // refused: FIFO full

        rst = 1'b1; en = 1'b0; clr = 1'b0; vld = 1'b1; smp = 3'sd2;
        step(); step();
        // Pushes during reset are ignored.
        chk("rst_stb", int'(stb), 0);
        chk("rst_fir", int'(fir), 0);
        chk("rst_lvl", int'(lvl), 0);
        chk("rst_uf", int'(uf), 0);
        chk("rst_rdy", int'(rdy), 1);
`ifdef FEEDER_UNDERFLOW_CNT_EN
        chk("rst_ucnt", int'(ucnt), 0);
`endif
        vld = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_lvl", int'(lvl), 0);

        // Back-to-back pushes with strobes disabled.
        for (int i = 0; i < 5; i++) begin
            vld = vecs[i].v;
            smp = vecs[i].s;
            step();
            chk($sformatf("push%0d_rdy", i), int'(rdy), int'(vecs[i].exp_rdy));
            chk($sformatf("push%0d_lvl", i), int'(lvl), int'(vecs[i].exp_lvl));
            chk($sformatf("push%0d_stb", i), int'(stb), 0);
        end
        vld = 1'b0;

        // Enable: first strobe 20 edges later, then every 20.
        en = 1'b1;
        wait_strobe(40, n);
        chk("first_period", n, 20);
        chk("pop0_fir", int'(fir), -4);
        chk("pop0_lvl", int'(lvl), 3);
        step();
        chk("stb_one_cycle", int'(stb), 0);
        chk("fir_hold", int'(fir), -4);
        wait_strobe(40, n);
        chk("period1", n, 19);
        chk("pop1_fir", int'(fir), -1);
        wait_strobe(40, n);
        chk("period2", n, 20);
        chk("pop2_fir", int'(fir), 0);
        chk("pop2_lvl", int'(lvl), 1);
        wait_strobe(40, n);
        chk("period3", n, 20);
        chk("pop3_fir", int'(fir), 3);
        chk("pop3_lvl", int'(lvl), 0);
        chk("pop3_uf", int'(uf), 0);

        // Underflow strobes.
        wait_strobe(40, n);
        chk("uf1_period", n, 20);
        chk("uf1_fir", int'(fir), 0);
        chk("uf1_uf", int'(uf), 1);
`ifdef FEEDER_UNDERFLOW_CNT_EN
        chk("uf1_cnt", int'(ucnt), 1);
`endif
        wait_strobe(40, n);
        chk("uf2_period", n, 20);
        chk("uf2_uf", int'(uf), 1);
`ifdef FEEDER_UNDERFLOW_CNT_EN
        chk("uf2_cnt", int'(ucnt), 2);
`endif

        // Clear, then push into the empty FIFO on the strobe edge.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_uf", int'(uf), 0);
`ifdef FEEDER_UNDERFLOW_CNT_EN
        chk("clr_cnt", int'(ucnt), 0);
`endif
        quiet(18, "pre_bypass_quiet");
        vld = 1'b1; smp = 3'sd2;
        step();
        vld = 1'b0;
        chk("nobyp_stb", int'(stb), 1);
        chk("nobyp_fir", int'(fir), 0);
        chk("nobyp_uf", int'(uf), 1);
        chk("nobyp_lvl", int'(lvl), 1);
        wait_strobe(40, n);
        chk("nobyp_period", n, 20);
        chk("nobyp_next_fir", int'(fir), 2);
        chk("nobyp_next_lvl", int'(lvl), 0);

        // Clear and underflow on the same edge: underflow wins.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr2_uf", int'(uf), 0);
        quiet(18, "pre_clrwin_quiet");
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrwin_stb", int'(stb), 1);
        chk("clrwin_uf", int'(uf), 1);
`ifdef FEEDER_UNDERFLOW_CNT_EN
        chk("clrwin_cnt", int'(ucnt), 1);
`endif

        // Fill while enabled, hold valid through the strobe edge.
        vld = 1'b1;
        smp = 3'sd1;  step();
        smp = 3'sd2;  step();
        smp = 3'sd3;  step();
        smp = -3'sd2; step();
        chk("full_lvl", int'(lvl), 4);
        chk("full_rdy", int'(rdy), 0);
        smp = -3'sd3;
        quiet(15, "full_hold_quiet");
        chk("full_hold_lvl", int'(lvl), 4);
        step();
        chk("fullpop_stb", int'(stb), 1);
        chk("fullpop_fir", int'(fir), 1);
        chk("fullpop_lvl", int'(lvl), 3);
        chk("fullpop_rdy", int'(rdy), 1);
        step();
        vld = 1'b0;
        chk("refill_lvl", int'(lvl), 4);

        // Counter now 1; run to 10, drop enable, re-enable.
        repeat (9) step();
        en = 1'b0;
        quiet(30, "disabled_quiet");
        en = 1'b1;
        wait_strobe(40, n);
        chk("reenable_period", n, 20);
        chk("reenable_fir", int'(fir), 2);
        chk("reenable_lvl", int'(lvl), 3);

        // Asynchronous reset mid-period with level 3.
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_fir", int'(fir), 0);
        chk("arst_lvl", int'(lvl), 0);
        chk("arst_uf", int'(uf), 0);
        chk("arst_stb", int'(stb), 0);
        chk("arst_rdy", int'(rdy), 1);
        step();
        rst = 1'b0;
        wait_strobe(40, n);
        chk("arst_period", n, 20);
        chk("arst_pop_fir", int'(fir), 0);
        chk("arst_pop_uf", int'(uf), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
